// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling and a small byte FIFO.
// Received bytes queue until the register logic pops them with RD.
module uart_rx_fifo #(
  parameter int CLK_HZ = 48000000,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     RX,
  input  logic                     RD,
  output logic [7:0]               DATA,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FERR,
  output logic                     OVR,
  input  logic                     CLR_ERR
);

  localparam int DIV = CLK_HZ / (16 * BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  logic          rx_meta_q, rxs_q;
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    data_q, data_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          ferr_q, ferr_d, ovr_q, ovr_d;
  logic          tick_s, rd_s, push_s, ferr_set_s, ovr_set_s;

  assign tick_s = (div_q == DIV_MAX);
  assign rd_s   = RD && !empty_q;

  // Receive FSM: start qualification, bit sampling and stop-bit disposition
  always_comb begin
    state_d    = state_q;
    div_d      = tick_s ? '0 : div_q + DW'(1);
    tick_d     = tick_s ? tick_q + 4'd1 : tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    ovr_set_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_START;
          div_d   = '0;
          tick_d  = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && tick_q == 4'd7) begin
          if (rxs_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            bit_d   = 3'd0;
            tick_d  = 4'd0;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && tick_q == 4'd15) begin
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? ST_STOP : ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s && tick_q == 4'd15) begin
          if (rxs_q) begin
            state_d = ST_IDLE;
            // A pop on the same edge frees the slot, so a full FIFO still accepts
            if (!full_q || rd_s) begin
              push_s = 1'b1;
            end else begin
              ovr_set_s = 1'b1;
            end
          end else begin
            ferr_set_s = 1'b1;
            state_d    = ST_WAIT_HIGH;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointers, occupancy, registered head byte and sticky error flags
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !rd_s) begin
      count_d = count_q + CW'(1);
    end else if (rd_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == COUNT_FULL);
    // The new head may be the byte being written this very cycle
    if (empty_d) begin
      data_d = 8'h00;
    end else if (push_s && rd_ptr_d == wr_ptr_q) begin
      data_d = shift_q;
    end else begin
      data_d = mem_q[rd_ptr_d];
    end
    ferr_d = ferr_set_s | (ferr_q & ~CLR_ERR);
    ovr_d  = ovr_set_s | (ovr_q & ~CLR_ERR);
  end

  // State registers; synchroniser resets to the idle-high line level
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= ST_IDLE;
      div_q     <= '0;
      tick_q    <= 4'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_q    <= 8'h00;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign DATA  = data_q;
  assign EMPTY = empty_q;
  assign FULL  = full_q;
  assign COUNT = count_q;
  assign FERR  = ferr_q;
  assign OVR   = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=10 (160 clocks per bit), DEPTH=4.
module tb_uart_rx_fifo;

  logic       CLK = 1'b0;
  logic       RESET, RX, RD, CLR_ERR;
  logic [7:0] DATA;
  logic       EMPTY, FULL, FERR, OVR;
  logic [2:0] COUNT;
  int         errors = 0;
  int         checks = 0;

  uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(10000), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .RX(RX), .RD(RD), .DATA(DATA), .EMPTY(EMPTY),
    .FULL(FULL), .COUNT(COUNT), .FERR(FERR), .OVR(OVR), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drives start, 8 data bits and the stop level; returns on the negedge just
  // before the stop-sample edge (82 clocks into the stop bit).
  task automatic frame(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    cyc(160);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      cyc(160);
    end
    RX = stop;
    cyc(82);
  endtask

  task automatic pop();
    RD = 1'b1;
    cyc(1);
    RD = 1'b0;
  endtask

  task automatic clr();
    CLR_ERR = 1'b1;
    cyc(1);
    CLR_ERR = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; RX = 1'b1; RD = 1'b0; CLR_ERR = 1'b0;
    cyc(3);
    chk("rst_empty", 8'(EMPTY), 8'h01);
    chk("rst_full",  8'(FULL),  8'h00);
    chk("rst_count", 8'(COUNT), 8'h00);
    chk("rst_data",  DATA,      8'h00);
    chk("rst_ferr",  8'(FERR),  8'h00);
    chk("rst_ovr",   8'(OVR),   8'h00);
    RESET = 1'b0;
    cyc(5);

    // Single byte: push lands exactly on the stop-sample edge
    frame(8'hA5, 1'b1);
    chk("a5_empty_before", 8'(EMPTY), 8'h01);
    cyc(1);
    chk("a5_empty",  8'(EMPTY), 8'h00);
    chk("a5_data",   DATA,      8'hA5);
    chk("a5_count",  8'(COUNT), 8'h01);
    chk("a5_ferr",   8'(FERR),  8'h00);
    chk("a5_ovr",    8'(OVR),   8'h00);
    cyc(77);
    pop();
    chk("a5_pop_empty", 8'(EMPTY), 8'h01);
    chk("a5_pop_data",  DATA,      8'h00);
    chk("a5_pop_count", 8'(COUNT), 8'h00);

    // Short low glitch is rejected at the mid-start sample
    RX = 1'b0;
    cyc(40);
    RX = 1'b1;
    cyc(300);
    chk("glitch_count", 8'(COUNT), 8'h00);
    chk("glitch_empty", 8'(EMPTY), 8'h01);
    chk("glitch_ferr",  8'(FERR),  8'h00);
    chk("glitch_ovr",   8'(OVR),   8'h00);

    // Framing error followed by a held-low break, then recovery
    frame(8'h3C, 1'b0);
    cyc(78 + 480);
    chk("ferr_set",   8'(FERR),  8'h01);
    chk("ferr_count", 8'(COUNT), 8'h00);
    RX = 1'b1;
    cyc(20);
    frame(8'h11, 1'b1);
    cyc(1);
    chk("r11_data",   DATA,      8'h11);
    chk("r11_count",  8'(COUNT), 8'h01);
    chk("ferr_stick", 8'(FERR),  8'h01);
    cyc(77);
    clr();
    chk("ferr_clr", 8'(FERR), 8'h00);
    pop();
    chk("r11_pop_empty", 8'(EMPTY), 8'h01);

    // Overrun: fifth byte into a full FIFO is dropped
    for (int b = 1; b <= 5; b++) begin
      frame(8'(b), 1'b1);
      cyc(78);
    end
    chk("ovr_full",  8'(FULL),  8'h01);
    chk("ovr_count", 8'(COUNT), 8'h04);
    chk("ovr_flag",  8'(OVR),   8'h01);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_read", DATA, 8'(i));
      pop();
    end
    chk("ovr_drain_empty", 8'(EMPTY), 8'h01);
    chk("ovr_drain_data",  DATA,      8'h00);
    clr();
    chk("ovr_clr", 8'(OVR), 8'h00);

    // Full FIFO with RD on the stop-sample edge: push and pop both happen
    for (int b = 10; b <= 13; b++) begin
      frame(8'(b), 1'b1);
      cyc(78);
    end
    chk("sim_full_pre", 8'(FULL), 8'h01);
    frame(8'h05, 1'b1);
    pop();
    chk("sim_ovr",   8'(OVR),   8'h00);
    chk("sim_count", 8'(COUNT), 8'h04);
    chk("sim_full",  8'(FULL),  8'h01);
    chk("sim_head",  DATA,      8'h0B);
    cyc(77);
    chk("sim_r0", DATA, 8'h0B);
    pop();
    chk("sim_r1", DATA, 8'h0C);
    pop();
    chk("sim_r2", DATA, 8'h0D);
    pop();
    chk("sim_r3", DATA, 8'h05);
    pop();
    chk("sim_empty", 8'(EMPTY), 8'h01);

    // Reset mid-character with a byte queued and FERR set
    frame(8'h55, 1'b1);
    cyc(78);
    frame(8'h00, 1'b0);
    cyc(78);
    RX = 1'b1;
    cyc(20);
    chk("pre_rst_ferr",  8'(FERR),  8'h01);
    chk("pre_rst_count", 8'(COUNT), 8'h01);
    RX = 1'b0;
    cyc(160 + 640);
    RX = 1'b1;
    cyc(80);
    RESET = 1'b1;
    cyc(2);
    chk("mid_rst_data",  DATA,      8'h00);
    chk("mid_rst_empty", 8'(EMPTY), 8'h01);
    chk("mid_rst_full",  8'(FULL),  8'h00);
    chk("mid_rst_count", 8'(COUNT), 8'h00);
    chk("mid_rst_ferr",  8'(FERR),  8'h00);
    chk("mid_rst_ovr",   8'(OVR),   8'h00);
    cyc(5);
    RESET = 1'b0;
    cyc(720);
    chk("post_rst_count", 8'(COUNT), 8'h00);
    frame(8'h7E, 1'b1);
    cyc(1);
    chk("r7e_data",  DATA,      8'h7E);
    chk("r7e_count", 8'(COUNT), 8'h01);
    chk("r7e_ferr",  8'(FERR),  8'h00);
    cyc(2000);
    chk("r7e_count_hold", 8'(COUNT), 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
